diverge_ctrl: RTL and testbench

- Receive-side counterpart of the converged packet stream: takes one stream_in per cycle and splits it back out.
- Data packets go to the addressed input-port write interface. Freespace-update packets go to the addressed output port as a one-cycle update pulse.
- When the addressed input port is full, the block buffers the packet in a 2-entry retry buffer and asserts resend to the upstream converging block. It drains the buffer in order once the port has space.

---
 rtl/diverge_ctrl_pkg.sv | 20 ++
 rtl/diverge_retry_buf.sv | 42 ++++
 rtl/diverge_ctrl.sv | 142 ++++++++++++++
 tb/tb_diverge_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/diverge_ctrl_pkg.sv
// diverge_ctrl shared definitions: packet field offsets, packet type
// codes and FSM state encoding used by the receive-side splitter.
package diverge_ctrl_pkg;

    // Default packet geometry. Field offsets below are tied to it.
    localparam int PKT_BITS  = 97;
    localparam int PORT_BITS = 4;

    localparam int VALID_BIT = PKT_BITS - 1;
    localparam int TYPE_BIT  = PKT_BITS - 2;
    localparam int PORT_MSB  = PKT_BITS - 3;

    localparam logic TYPE_UPDATE = 1'b1;
    localparam logic TYPE_DATA   = 1'b0;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] DRAIN_GAP = 2'd2;

endpackage

// File: rtl/diverge_retry_buf.sv
// diverge_retry_buf: 2-entry FIFO holding blocked data packets.
// Ports: clk, rst_n (async low), push/push_data, pop, head, count.
import diverge_ctrl_pkg::*;

module diverge_retry_buf #(
    parameter int W = PKT_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/diverge_ctrl.sv
// diverge_ctrl: splits the converged stream into per-input-port data
// writes and per-output-port freespace updates, with a 2-deep replay
// buffer and resend back-pressure when a target input port is full.
// Ports: clk, rst_n, stream_in, resend, packet_to_input_ports,
// input_port_wr_en, input_port_full, update_to_output_ports,
// update_valid, bad_port_cnt.
import diverge_ctrl_pkg::*;

module diverge_ctrl #(
    parameter int PACKET_BITS   = PKT_BITS,
    parameter int NUM_PORT_BITS = PORT_BITS,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PACKET_BITS-1:0]              stream_in,
    output logic                                resend,
    output logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_to_input_ports,
    output logic [NUM_IN_PORTS-1:0]             input_port_wr_en,
    input  logic [NUM_IN_PORTS-1:0]             input_port_full,
    output logic [PACKET_BITS*NUM_OUT_PORTS-1:0] update_to_output_ports,
    output logic [NUM_OUT_PORTS-1:0]            update_valid,
    output logic [15:0]                         bad_port_cnt
);

    localparam int FULL_W = 2 ** NUM_PORT_BITS;

    logic [1:0]               state;
    logic                     hold_first;
    logic                     s_valid;
    logic                     s_type;
    logic [NUM_PORT_BITS-1:0] s_port;
    logic                     accept;
    logic                     upd_ok;
    logic                     data_ok;
    logic                     is_upd;
    logic                     is_data;
    logic                     bad;
    logic                     direct;
    logic                     push;
    logic                     pop;
    logic [PACKET_BITS-1:0]   buf_head;
    logic [1:0]               buf_cnt;
    logic [NUM_PORT_BITS-1:0] head_port;
    logic [FULL_W-1:0]        full_ext;
    logic [NUM_IN_PORTS-1:0]  wr_sel;
    logic [NUM_OUT_PORTS-1:0] upd_sel;
    logic [PACKET_BITS-1:0]   wr_data;

    assign s_valid   = stream_in[VALID_BIT];
    assign s_type    = stream_in[TYPE_BIT];
    assign s_port    = stream_in[PORT_MSB -: NUM_PORT_BITS];
    assign head_port = buf_head[PORT_MSB -: NUM_PORT_BITS];
    // Widened so any 4-bit index lands inside the vector.
    assign full_ext  = FULL_W'(input_port_full);

    // Only the first HOLD cycle still carries a fresh packet; later
    // HOLD cycles and the gap cycle carry upstream replays.
    assign accept  = s_valid
                   && (state == IDLE || (state == HOLD && hold_first));
    assign upd_ok  = s_port < NUM_PORT_BITS'(NUM_OUT_PORTS);
    assign data_ok = s_port < NUM_PORT_BITS'(NUM_IN_PORTS);
    assign is_upd  = accept && s_type == TYPE_UPDATE && upd_ok;
    assign is_data = accept && s_type == TYPE_DATA && data_ok;
    assign bad     = accept && ((s_type == TYPE_UPDATE && !upd_ok)
                             || (s_type == TYPE_DATA && !data_ok));

    // A non-empty buffer forces queueing so packet order is kept.
    assign direct  = is_data && buf_cnt == 2'd0 && !full_ext[s_port];
    assign push    = is_data && !direct;
    assign pop     = state == HOLD && buf_cnt != 2'd0
                   && !full_ext[head_port];

    assign wr_sel  = direct ? NUM_IN_PORTS'(1) << s_port
                   : pop    ? NUM_IN_PORTS'(1) << head_port
                   : '0;
    assign wr_data = direct ? stream_in : buf_head;
    assign upd_sel = is_upd ? NUM_OUT_PORTS'(1) << s_port : '0;

    diverge_retry_buf #(
        .W(PACKET_BITS)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(stream_in),
        .pop      (pop),
        .head     (buf_head),
        .count    (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            hold_first             <= 1'b0;
            resend                 <= 1'b0;
            packet_to_input_ports  <= '0;
            input_port_wr_en       <= '0;
            update_to_output_ports <= '0;
            update_valid           <= '0;
            bad_port_cnt           <= 16'd0;
        end else begin
            input_port_wr_en <= wr_sel;
            update_valid     <= upd_sel;
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                if (wr_sel[i]) begin
                    packet_to_input_ports[i*PACKET_BITS +: PACKET_BITS]
                        <= wr_data;
                end
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (upd_sel[i]) begin
                    update_to_output_ports[i*PACKET_BITS +: PACKET_BITS]
                        <= stream_in;
                end
            end
            if (bad && bad_port_cnt != 16'hFFFF) begin
                bad_port_cnt <= bad_port_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (push) begin
                        state      <= HOLD;
                        hold_first <= 1'b1;
                        resend     <= 1'b1;
                    end
                end
                HOLD: begin
                    hold_first <= 1'b0;
                    if (pop && buf_cnt == 2'd1 && !push) begin
                        state  <= DRAIN_GAP;
                        resend <= 1'b0;
                    end
                end
                DRAIN_GAP: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diverge_ctrl.sv
// tb_diverge_ctrl: directed and random checks of diverge_ctrl against
// a queue-based behavioural model of the splitter.
module tb_diverge_ctrl;

    localparam int PB = 97;
    localparam int NI = 7;
    localparam int NO = 7;
    localparam int W  = PB * NI;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PB-1:0] stream_in = '0;
    logic          resend;
    logic [W-1:0]  pkt_in;
    logic [NI-1:0] wr_en;
    logic [NI-1:0] full = '0;
    logic [W-1:0]  upd;
    logic [NO-1:0] upd_v;
    logic [15:0]   bad_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Model: pending retry queue, accept window and expected outputs.
    logic [PB-1:0] q[$];
    int            m_mode;
    bit            m_first;
    logic [PB-1:0] m_in [NI];
    logic [PB-1:0] m_upd [NO];
    logic [NI-1:0] e_wr;
    logic [NO-1:0] e_uv;
    int            m_bad;

    diverge_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stream_in             (stream_in),
        .resend                (resend),
        .packet_to_input_ports (pkt_in),
        .input_port_wr_en      (wr_en),
        .input_port_full       (full),
        .update_to_output_ports(upd),
        .update_valid          (upd_v),
        .bad_port_cnt          (bad_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PB-1:0] mkpkt(input bit v, input bit t,
                                            input int p,
                                            input logic [90:0] pay);
        return {v, t, 4'(p), pay};
    endfunction

    function automatic logic [90:0] rpay();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[90:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode  = 0;
        m_first = 0;
        for (int i = 0; i < NI; i++) m_in[i] = '0;
        for (int i = 0; i < NO; i++) m_upd[i] = '0;
        e_wr  = '0;
        e_uv  = '0;
        m_bad = 0;
    endtask

    task automatic bump_bad();
        if (m_bad < 65535) m_bad++;
    endtask

    // mode: 0 idle, 1 holding (resend high), 2 one ignored cycle
    task automatic model_step(input logic [PB-1:0] s,
                              input logic [NI-1:0] f);
        bit            acc;
        bit            pushed;
        int            p;
        logic [PB-1:0] h;
        pushed = 0;
        e_wr   = '0;
        e_uv   = '0;
        acc = s[PB-1] && (m_mode == 0 || (m_mode == 1 && m_first));
        if (m_mode == 1 && q.size() > 0) begin
            h = q[0];
            p = int'(h[94:91]);
            if (!f[p]) begin
                e_wr[p] = 1'b1;
                m_in[p] = h;
                h = q.pop_front();
            end
        end
        if (acc) begin
            p = int'(s[94:91]);
            if (s[95]) begin
                if (p < NO) begin
                    e_uv[p]  = 1'b1;
                    m_upd[p] = s;
                end else begin
                    bump_bad();
                end
            end else if (p >= NI) begin
                bump_bad();
            end else if (m_mode == 0 && q.size() == 0 && !f[p]) begin
                e_wr[p] = 1'b1;
                m_in[p] = s;
            end else begin
                q.push_back(s);
                pushed = 1;
                chk("no_overflow", W'(q.size() <= 2), W'(1));
            end
        end
        case (m_mode)
            0: if (pushed) begin
                m_mode  = 1;
                m_first = 1;
            end
            1: begin
                m_first = 0;
                if (q.size() == 0) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] ei;
        logic [W-1:0] eu;
        for (int i = 0; i < NI; i++) ei[i*PB +: PB] = m_in[i];
        for (int i = 0; i < NO; i++) eu[i*PB +: PB] = m_upd[i];
        chk({tag, ".resend"}, W'(resend), W'(m_mode == 1));
        chk({tag, ".wr_en"}, W'(wr_en), W'(e_wr));
        chk({tag, ".upd_v"}, W'(upd_v), W'(e_uv));
        chk({tag, ".bad"}, W'(bad_cnt), W'(m_bad));
        chk({tag, ".pkt"}, pkt_in, ei);
        chk({tag, ".upd"}, upd, eu);
    endtask

    task automatic cyc(input logic [PB-1:0] s, input logic [NI-1:0] f,
                       input string tag);
        stream_in = s;
        full      = f;
        model_step(s, f);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [PB-1:0] a;
        logic [PB-1:0] u;
        logic [PB-1:0] d1;
        logic [PB-1:0] d2;
        logic [PB-1:0] d3;
        logic [NI-1:0] rf;

        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        a = mkpkt(1, 0, 2, 91'hAA);
        cyc(a, '0, "data_p2");
        chk("tp_wr_p2", W'(wr_en), W'(7'b0000100));
        chk("tp_pkt_p2", W'(pkt_in[2*PB +: PB]), W'(a));
        chk("tp_no_resend", W'(resend), W'(0));
        cyc('0, '0, "idle0");

        u = mkpkt(1, 1, 5, rpay());
        cyc(u, 7'h7F, "upd_p5");
        chk("tp_uv_p5", W'(upd_v), W'(7'b0100000));
        chk("tp_upd_bus5", W'(upd[5*PB +: PB]), W'(u));
        chk("tp_upd_noresend", W'(resend), W'(0));
        cyc('0, 7'h7F, "upd_after");
        chk("tp_uv_once", W'(upd_v), W'(0));

        d1 = mkpkt(1, 0, 1, rpay());
        d3 = mkpkt(1, 0, 3, rpay());
        cyc(d1, 7'b0000010, "hold_p1");
        chk("tp_resend_up", W'(resend), W'(1));
        cyc(d3, 7'b0000010, "hold_p3");
        chk("tp_p3_buffered", W'(wr_en), W'(0));
        repeat (4) cyc(d3, 7'b0000010, "hold_wait");
        cyc(d3, '0, "drain_p1");
        chk("tp_drain_p1", W'(wr_en), W'(7'b0000010));
        chk("tp_drain_pkt1", W'(pkt_in[1*PB +: PB]), W'(d1));
        cyc(d3, '0, "drain_p3");
        chk("tp_drain_p3", W'(wr_en), W'(7'b0001000));
        chk("tp_drain_pkt3", W'(pkt_in[3*PB +: PB]), W'(d3));
        chk("tp_resend_down", W'(resend), W'(0));
        cyc(d3, '0, "gap");
        chk("tp_gap_ignored", W'(wr_en), W'(0));
        cyc('0, '0, "idle1");

        cyc(mkpkt(1, 0, 7, rpay()), '0, "bad7");
        cyc(mkpkt(1, 1, 12, rpay()), '0, "bad12");
        chk("tp_bad2", W'(bad_cnt), W'(2));
        chk("tp_bad_nowr", W'(wr_en), W'(0));

        for (int i = 0; i < 20; i++) begin
            a = mkpkt(0, 1'($urandom), $urandom_range(0, 15), rpay());
            cyc(a, NI'($urandom), "invalid");
        end
        chk("tp_invalid_idle", W'(resend), W'(0));

        for (int i = 0; i < 400; i++) begin
            a = mkpkt($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                      $urandom_range(0, 8), rpay());
            rf = NI'($urandom & $urandom);
            cyc(a, rf, "rand");
        end

        repeat (4) cyc('0, '0, "settle");
        d1 = mkpkt(1, 0, 1, rpay());
        d2 = mkpkt(1, 0, 2, rpay());
        cyc(d1, 7'b0000110, "mr_p1");
        cyc(d2, 7'b0000110, "mr_p2");
        chk("tp_mr_hold", W'(resend), W'(1));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        chk("tp_mr_resend0", W'(resend), W'(0));
        chk("tp_mr_cnt0", W'(bad_cnt), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc('0, '0, "post_reset");

        for (int i = 0; i < 65537; i++) begin
            cyc(mkpkt(1, 1, 12, '0), '0, "sat");
        end
        chk("tp_sat", W'(bad_cnt), W'(16'hFFFF));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
